// File: rtl/hazard_scheduler_pkg.sv
// Shared definitions for the hazard scheduler slice.
// Holds the id_ctrl field positions, the scheduler state encoding and the
// default geometry parameters.
package hazard_scheduler_pkg;

  // id_ctrl field positions
  localparam int RS_HI        = 24;
  localparam int RS_LO        = 20;
  localparam int RT_HI        = 19;
  localparam int RT_LO        = 15;
  localparam int RD_HI        = 14;
  localparam int RD_LO        = 10;
  localparam int WR_REGFILE_B = 9;
  localparam int MUX_IMM_B    = 8;
  localparam int ALU_SEL_HI   = 7;
  localparam int ALU_SEL_LO   = 6;
  localparam int MUL_START_B  = 5;
  localparam int MUX2_ALU_B   = 4;
  localparam int WR_MEM_B     = 3;
  localparam int CS_WB2_B     = 2;
  localparam int BRANCH_B     = 1;
  localparam int JMP_B        = 0;

  // Geometry defaults: EX, MEM, WB between issue and register-file write
  localparam int PIPE_DEPTH_DEF = 3;
  localparam int REG_W_DEF      = 5;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } sched_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight register-write tracker.
// A PIPE_DEPTH-deep shift register of {valid, rd} entries that advances every
// clock, plus a two-port comparator against the ID source registers.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_rd     load entry 0 with {1, push_rd} when push, else empty
//   query_rs/rt       ID source register addresses
//   hit_rs/rt         source matches a valid in-flight destination (r0 never hits)
module hazard_scoreboard
  import hazard_scheduler_pkg::*;
#(
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
  parameter int REG_W      = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [REG_W-1:0] push_rd,
  input  logic [REG_W-1:0] query_rs,
  input  logic [REG_W-1:0] query_rt,
  output logic             hit_rs,
  output logic             hit_rt
);

  logic [PIPE_DEPTH-1:0] vld_q;
  logic [REG_W-1:0]      rd_q [PIPE_DEPTH];

  // Shift stage: entry PIPE_DEPTH-1 is in WB and drops out at the next edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) rd_q[i] <= '0;
    end else begin
      vld_q[0] <= push;
      rd_q[0]  <= push ? push_rd : '0;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        rd_q[i]  <= rd_q[i-1];
      end
    end
  end

  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (vld_q[i] && (rd_q[i] == query_rs) && (query_rs != '0)) hit_rs = 1'b1;
      if (vld_q[i] && (rd_q[i] == query_rt) && (query_rt != '0)) hit_rt = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Issue/stall/bubble/flush sequencer for the single-issue pipeline.
// No forwarding: RAW hazards stall until the producer retires from WB.
// The multi-cycle multiplier holds the whole pipeline from issue to mul_done.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   id_valid, id_ctrl ID-stage instruction and its 25-bit decoded control word
//   ex_branch_taken   taken BNE resolving in EX
//   mul_done          multiplier result pulse
//   issue             ID instruction advances to EX
//   pc_stall          hold PC
//   if_id_stall       hold IF/ID
//   id_ex_bubble      load all-zero control into ID/EX
//   if_id_flush       clear IF/ID at the next edge
//   mul_busy          registered, high while waiting on the multiplier
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
  parameter int REG_W      = REG_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [24:0] id_ctrl,
  input  logic        ex_branch_taken,
  input  logic        mul_done,
  output logic        issue,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        mul_busy
);

  sched_state_t     state_q, state_d;
  logic [REG_W-1:0] mul_rd_q, mul_rd_d;

  logic [REG_W-1:0] rs, rt, rd;
  logic             wr_regfile, mux_imm, mul_start, wr_mem, jmp;
  logic             uses_rs, uses_rt, hit_rs, hit_rt, hazard;
  logic             push;
  logic [REG_W-1:0] push_rd;
  logic             unused_ctrl;

  assign rs         = id_ctrl[RS_HI:RS_LO];
  assign rt         = id_ctrl[RT_HI:RT_LO];
  assign rd         = id_ctrl[RD_HI:RD_LO];
  assign wr_regfile = id_ctrl[WR_REGFILE_B];
  assign mux_imm    = id_ctrl[MUX_IMM_B];
  assign mul_start  = id_ctrl[MUL_START_B];
  assign wr_mem     = id_ctrl[WR_MEM_B];
  assign jmp        = id_ctrl[JMP_B];

  // Datapath-only fields; the scheduler never looks at them
  assign unused_ctrl = ^{id_ctrl[ALU_SEL_HI:ALU_SEL_LO], id_ctrl[MUX2_ALU_B],
                         id_ctrl[CS_WB2_B], id_ctrl[BRANCH_B]};

  // Jumps carry no rs; stores read rt even though they use the immediate
  assign uses_rs = !jmp;
  assign uses_rt = !mux_imm | wr_mem;

  // A MUL destination reaches the scoreboard on the mul_done cycle, so any
  // consumer waiting in ID is covered by the scoreboard once RUN resumes.
  assign hazard = id_valid & ((uses_rs & hit_rs) | (uses_rt & hit_rt));

  assign mul_busy = (state_q == MUL_WAIT);

  hazard_scoreboard #(
    .PIPE_DEPTH (PIPE_DEPTH),
    .REG_W      (REG_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_rd  (push_rd),
    .query_rs (rs),
    .query_rt (rt),
    .hit_rs   (hit_rs),
    .hit_rt   (hit_rt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      mul_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      mul_rd_q <= mul_rd_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mul_rd_d     = mul_rd_q;
    issue        = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    push         = 1'b0;
    push_rd      = '0;
    case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          // Wrong-path ID instruction is dropped, MUL included
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (hazard) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (id_valid) begin
          issue = 1'b1;
          if (mul_start) begin
            mul_rd_d = rd;
            state_d  = MUL_WAIT;
          end else begin
            if_id_flush = jmp;
            if (wr_regfile && (rd != '0)) begin
              push    = 1'b1;
              push_rd = rd;
            end
          end
        end
      end
      MUL_WAIT: begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
        if (mul_done) begin
          state_d = RUN;
          if (mul_rd_q != '0) begin
            push    = 1'b1;
            push_rd = mul_rd_q;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
module tb_hazard_scheduler;

  localparam int D = 3;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [24:0] id_ctrl;
  logic        ex_branch_taken;
  logic        mul_done;
  logic        issue, pc_stall, if_id_stall, id_ex_bubble, if_id_flush, mul_busy;

  int errors = 0;
  int checks = 0;

  // Reference model: cycle at which each register becomes readable again,
  // plus whether the multiplier is outstanding and its destination.
  int busy_until [32];
  int cyc = 0;
  bit m_wait = 0;
  int m_rd = 0;

  hazard_scheduler #(.PIPE_DEPTH(D), .REG_W(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_ctrl         (id_ctrl),
    .ex_branch_taken (ex_branch_taken),
    .mul_done        (mul_done),
    .issue           (issue),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .id_ex_bubble    (id_ex_bubble),
    .if_id_flush     (if_id_flush),
    .mul_busy        (mul_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [24:0] mk(input int rs, input int rt, input int rd,
                                     input bit wr, input bit imm, input bit mul,
                                     input bit wrmem, input bit jmp);
    logic [24:0] c;
    c = '0;
    c[24:20] = rs[4:0];
    c[19:15] = rt[4:0];
    c[14:10] = rd[4:0];
    c[9] = wr;
    c[8] = imm;
    c[5] = mul;
    c[3] = wrmem;
    c[0] = jmp;
    return c;
  endfunction

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) busy_until[i] = 0;
    m_wait = 0;
    m_rd = 0;
  endtask

  // One clock cycle: drive, compare combinational + registered outputs
  // against the model, then advance the model across the coming edge.
  task automatic step(input bit v, input logic [24:0] c, input bit br, input bit md);
    int rs, rt, rd;
    bit u_rs, u_rt, haz;
    bit e_iss, e_stall, e_bub, e_fl;
    @(negedge clk);
    id_valid = v;
    id_ctrl = c;
    ex_branch_taken = br;
    mul_done = md;
    #1;
    rs = int'(c[24:20]);
    rt = int'(c[19:15]);
    rd = int'(c[14:10]);
    u_rs = !c[0];
    u_rt = !c[8] || c[3];
    haz = v && ((u_rs && rs != 0 && busy_until[rs] > cyc) ||
                (u_rt && rt != 0 && busy_until[rt] > cyc));
    e_iss = 0; e_stall = 0; e_bub = 0; e_fl = 0;
    check("mul_busy", mul_busy, m_wait);
    if (m_wait) begin
      e_stall = 1; e_bub = 1;
      if (md) begin
        if (m_rd != 0) busy_until[m_rd] = cyc + D + 1;
        m_wait = 0;
      end
    end else if (br) begin
      e_fl = 1; e_bub = 1;
    end else if (haz) begin
      e_stall = 1; e_bub = 1;
    end else if (v) begin
      e_iss = 1;
      if (c[5]) begin
        m_wait = 1;
        m_rd = rd;
      end else begin
        e_fl = c[0];
        if (c[9] && rd != 0) busy_until[rd] = cyc + D + 1;
      end
    end
    check("issue", issue, e_iss);
    check("pc_stall", pc_stall, e_stall);
    check("if_id_stall", if_id_stall, e_stall);
    check("id_ex_bubble", id_ex_bubble, e_bub);
    check("if_id_flush", if_id_flush, e_fl);
    cyc++;
  endtask

  initial begin
    logic [24:0] add_r3, add_r4, addi_r0, add_r5, mul_r6, add_r7, jmp_i, add_r8, rc;
    add_r3  = mk(1, 2, 3, 1, 0, 0, 0, 0);
    add_r4  = mk(3, 1, 4, 1, 0, 0, 0, 0);
    addi_r0 = mk(1, 0, 0, 1, 1, 0, 0, 0);
    add_r5  = mk(0, 0, 5, 1, 0, 0, 0, 0);
    mul_r6  = mk(1, 2, 6, 1, 0, 1, 0, 0);
    add_r7  = mk(6, 1, 7, 1, 0, 0, 0, 0);
    jmp_i   = mk(0, 0, 0, 0, 1, 0, 0, 1);
    add_r8  = mk(6, 1, 8, 1, 0, 0, 0, 0);

    model_reset();
    rst = 1'b1;
    id_valid = 0; id_ctrl = '0; ex_branch_taken = 0; mul_done = 0;
    #23;
    check("rst_issue", issue, 1'b0);
    check("rst_pc_stall", pc_stall, 1'b0);
    check("rst_bubble", id_ex_bubble, 1'b0);
    check("rst_flush", if_id_flush, 1'b0);
    check("rst_mul_busy", mul_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // RAW on r3: three stalls, issue on the fourth cycle
    step(1, add_r3, 0, 0);
    for (int i = 0; i < 4; i++) step(1, add_r4, 0, 0);
    step(0, '0, 0, 0);
    // r0 writes never create a hazard
    step(1, addi_r0, 0, 0);
    step(1, add_r5, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0);
    // MUL with mul_done five cycles after issue, dependent ADD waiting
    step(1, mul_r6, 0, 0);
    for (int i = 0; i < 4; i++) step(1, add_r7, 1, 0);
    step(1, add_r7, 0, 1);
    for (int i = 0; i < 4; i++) step(1, add_r7, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0);
    // Jump flushes once, next instruction issues normally
    step(1, jmp_i, 0, 0);
    step(1, add_r5, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0);
    // Taken branch while a hazarding ADD sits in ID; no push results
    step(1, add_r3, 0, 0);
    step(1, add_r4, 1, 0);
    step(1, mul_r6, 1, 0);
    step(1, add_r4, 0, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 0, 0);

    // Async reset in the middle of MUL_WAIT
    step(1, mul_r6, 0, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    @(negedge clk);
    id_valid = 0; id_ctrl = '0; ex_branch_taken = 0; mul_done = 0;
    #2;
    check("pre_rst_mul_busy", mul_busy, 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst_mul_busy", mul_busy, 1'b0);
    check("async_rst_pc_stall", pc_stall, 1'b0);
    check("async_rst_bubble", id_ex_bubble, 1'b0);
    #1;
    rst = 1'b0;
    model_reset();
    cyc++;
    step(1, add_r8, 0, 0);
    step(0, '0, 0, 0);

    // Randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      rc = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 5) == 0));
      rc[7:6] = 2'($urandom_range(0, 3));
      rc[4] = 1'($urandom_range(0, 1));
      rc[2] = 1'($urandom_range(0, 1));
      rc[1] = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 3) != 0), rc, ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
